// File: rtl/acesso_pkg.sv
// Shared types and constants for the access gatekeeper: FSM state encoding,
// resource range and the reserved invalid resource id.
package acesso_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StCheck,
      StGrant,
      StDeny,
      StLocked
   } state_e;

   localparam int unsigned RESOURCE_COUNT = 7;
   localparam logic [2:0]  INVALID_ID     = 3'd7;

   function automatic int unsigned max_cycles(input int unsigned a, input int unsigned b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/contador_tempo.sv
// Loadable down-counter with synchronous reset; done is high while the count sits at zero.
// Loaded with N-1 so that a state waiting on done lasts exactly N cycles.
module contador_tempo #(
   parameter int unsigned Width = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [Width-1:0] load_value,
   output logic             done
);

   logic [Width-1:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (load) begin
         count_d = load_value;
      end else if (count_q != '0) begin
         count_d = count_q - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign done = (count_q == '0);

endmodule

// File: rtl/controle_acesso.sv
// Access gatekeeper: checks a snapshotted permission bit per accepted request and answers with
// a timed grant, a one-cycle deny or a timed lockout. AUDIT_COUNT_EN adds saturating counters.
module controle_acesso
   import acesso_pkg::*;
#(
   parameter int unsigned GRANT_CYCLES = 8,
   parameter int unsigned MAX_FAILS    = 3,
   parameter int unsigned LOCK_CYCLES  = 16
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [RESOURCE_COUNT-1:0] perm,
   input  logic                      req_valid,
   input  logic [2:0]                req_id,
   output logic                      req_ready,
   output logic                      grant,
   output logic                      deny,
   output logic                      locked,
`ifdef AUDIT_COUNT_EN
   output logic [7:0]                grant_count,
   output logic [7:0]                deny_count,
`endif
   output logic [2:0]                resource
);

   localparam int unsigned CntMax = max_cycles(GRANT_CYCLES, LOCK_CYCLES);
   localparam int unsigned CntW   = (CntMax > 1) ? $clog2(CntMax) : 1;
   localparam int unsigned FailW  = $clog2(MAX_FAILS + 1);

   state_e                    state_q, state_d;
   logic [FailW-1:0]          fail_q, fail_d;
   logic [RESOURCE_COUNT:0]   perm_snap_q;
   logic [2:0]                resource_q;
   logic                      grant_q, deny_q, locked_q;
   logic                      accept;
   logic                      pass;
   logic                      cnt_load;
   logic [CntW-1:0]           cnt_value;
   logic                      cnt_done;

   // Top snapshot bit is tied low so the invalid id always fails without an out-of-range select.
   assign pass = (resource_q != INVALID_ID) && perm_snap_q[resource_q];

   always_comb begin
      state_d   = state_q;
      fail_d    = fail_q;
      accept    = 1'b0;
      cnt_load  = 1'b0;
      cnt_value = '0;
      unique case (state_q)
         StIdle: begin
            if (req_valid) begin
               accept  = 1'b1;
               state_d = StCheck;
            end
         end
         StCheck: begin
            if (pass) begin
               fail_d    = '0;
               state_d   = StGrant;
               cnt_load  = 1'b1;
               cnt_value = CntW'(GRANT_CYCLES - 1);
            end else if (int'(fail_q) + 1 < int'(MAX_FAILS)) begin
               fail_d  = fail_q + 1'b1;
               state_d = StDeny;
            end else begin
               state_d   = StLocked;
               cnt_load  = 1'b1;
               cnt_value = CntW'(LOCK_CYCLES - 1);
            end
         end
         StGrant: begin
            if (cnt_done) begin
               state_d = StIdle;
            end
         end
         StDeny: begin
            state_d = StIdle;
         end
         StLocked: begin
            if (cnt_done) begin
               fail_d  = '0;
               state_d = StIdle;
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= StIdle;
         fail_q      <= '0;
         perm_snap_q <= '0;
         resource_q  <= '0;
         grant_q     <= 1'b0;
         deny_q      <= 1'b0;
         locked_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         fail_q   <= fail_d;
         grant_q  <= (state_d == StGrant);
         deny_q   <= (state_d == StDeny);
         locked_q <= (state_d == StLocked);
         if (accept) begin
            resource_q  <= req_id;
            perm_snap_q <= {1'b0, perm};
         end
      end
   end

   contador_tempo #(
      .Width (CntW)
   ) u_contador_tempo (
      .clk        (clk),
      .rst        (rst),
      .load       (cnt_load),
      .load_value (cnt_value),
      .done       (cnt_done)
   );

`ifdef AUDIT_COUNT_EN
   logic [7:0] grant_cnt_q, deny_cnt_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         grant_cnt_q <= '0;
         deny_cnt_q  <= '0;
      end else if (state_q == StCheck) begin
         if (state_d == StGrant) begin
            if (grant_cnt_q != 8'hFF) grant_cnt_q <= grant_cnt_q + 1'b1;
         end else begin
            if (deny_cnt_q != 8'hFF) deny_cnt_q <= deny_cnt_q + 1'b1;
         end
      end
   end

   assign grant_count = grant_cnt_q;
   assign deny_count  = deny_cnt_q;
`endif

   assign req_ready = (state_q == StIdle);
   assign grant     = grant_q;
   assign deny      = deny_q;
   assign locked    = locked_q;
   assign resource  = resource_q;

   a_outputs_exclusive : assert property (@(posedge clk) disable iff (rst)
      $onehot0({grant_q, deny_q, locked_q}));

   a_fail_bounded : assert property (@(posedge clk) disable iff (rst)
      (state_q == StIdle) |-> (int'(fail_q) < int'(MAX_FAILS)));

endmodule

// File: doc/controle_acesso.md
# controle_acesso

Sequential access gatekeeper that consumes the 7-bit permission vector produced by the authentication stage and enforces it on incoming resource requests. A requester presents a resource index with a valid/ready handshake; the block checks the snapshotted permission bit and answers with a timed grant, a one-cycle deny, or a timed lockout after repeated failures. It sits between the authentication logic and the actuators (door, terminal, alarm) of the digital access-control design.

## Interface
- GRANT_CYCLES, 8: cycles `grant` stays high per approved request (>=1)
- MAX_FAILS, 3: consecutive denials that trigger lockout (>=1)
- LOCK_CYCLES, 16: cycles `locked` stays high (>=1)

- clk  in  1  single system clock, rising edge
- rst  in  1  synchronous, active-high reset
- perm  in  7  permission vector from authentication stage; bit i enables resource i
- req_valid  in  1  request present
- req_id  in  3  requested resource; 0..6 valid, 7 invalid
- req_ready  out  1  block can accept a request
- grant  out  1  access granted for `resource`
- deny  out  1  one-cycle denial pulse
- locked  out  1  lockout active
- resource  out  3  resource index of the last accepted request
- grant_count  out  8  saturating count of grants (only with AUDIT_COUNT_EN)
- deny_count  out  8  saturating count of denials, lockout-causing denials included (only with AUDIT_COUNT_EN)

## Operation
- States: IDLE, CHECK, GRANT, DENY, LOCKED. Reset forces IDLE.
- Reset values: grant=deny=locked=0, resource=0, fail count=0, duration counter=0, audit counters=0; req_ready=1 from the first cycle after reset is sampled.
- req_ready = (state==IDLE), decoded from the state register; all other outputs are registered.
- IDLE: on req_valid && req_ready at an edge, capture req_id into `resource` and snapshot perm; go CHECK. perm changes after acceptance are ignored.
- CHECK (1 cycle): pass = (resource<=6) && perm_snap[resource].
  - pass: fail count cleared; go GRANT, load counter with GRANT_CYCLES.
  - fail and fail_count+1 < MAX_FAILS: increment fail count; go DENY.
  - fail and fail_count+1 == MAX_FAILS: go LOCKED, load counter with LOCK_CYCLES.
- GRANT: grant=1; counter decrements; on reaching terminal value return IDLE.
- DENY: deny=1 for exactly one cycle; return IDLE.
- LOCKED: locked=1; req_ready=0; counter decrements; on exit fail count cleared, return IDLE.
- Fail count width $clog2(MAX_FAILS+1); never exceeds MAX_FAILS-1 in IDLE.
- req_id=7 is always a failure regardless of perm.
- Reset mid-GRANT or mid-LOCKED aborts at that edge: outputs drop to reset values next cycle; lockout is not remembered.

## Timing
- Handshake accepted at edge k: CHECK in cycle k+1; grant/deny/locked high starting cycle k+2.
- grant high cycles k+2 .. k+1+GRANT_CYCLES; req_ready high again in cycle k+2+GRANT_CYCLES.
- deny high in cycle k+2 only; req_ready high in cycle k+3.
- locked high cycles k+2 .. k+1+LOCK_CYCLES; req_ready high in cycle k+2+LOCK_CYCLES.
- Back-to-back: a request held valid through the ready gap is accepted on the first edge req_ready=1.
- grant, deny, locked are mutually exclusive every cycle.

## Configuration
- AUDIT_COUNT_EN defined: grant_count/deny_count ports present; each increments by 1 on entry to GRANT / on entry to DENY or LOCKED, saturating at 255, cleared by rst.
- Not defined: ports and counters absent; all other behaviour identical.

## Structure
- Package acesso_pkg: state enum (IDLE, CHECK, GRANT, DENY, LOCKED), RESOURCE_COUNT=7, INVALID_ID=3'd7.
- One sub-module: contador_tempo, loadable down-counter with sync reset and `done` flag, shared by GRANT and LOCKED durations.

## Test plan
- Reset, perm=7'b0000101, request id 2 -> grant high for 8 cycles starting 2 cycles after handshake, resource=2, req_ready low throughout.
- perm=7'b0000001, request id 1 -> single deny pulse at k+2, req_ready at k+3, fail count 1.
- Three consecutive failures (ids 3, 7, 5, perm=0) -> deny, deny, then locked for 16 cycles; fourth request ignored until req_ready returns; next valid request grants.
- Failure, then success, then two failures -> no lockout (success clears count).
- perm toggled to 0 in CHECK cycle after accepting id 0 with perm bit set -> grant still issued.
- rst asserted mid-LOCKED -> locked=0, req_ready=1 next cycle; with AUDIT_COUNT_EN, 300 grants -> grant_count=255.
